tape_mem_arbiter: RTL

// - Shares the single tape-image SDRAM port between two requesters: the ioctl download writer (port W) and the cassette player read path (port R).
// - One transaction outstanding at a time; W has fixed priority; R data is registered and held for the player.
// - Tracks the image length during download and publishes tape_end to the cassette player.
// - Sits between the cassette/download logic and the SDRAM controller channel.

---
 rtl/tape_pkg.sv | 6 +
 rtl/tape_mem_arbiter.sv | 105 ++++++++++
 2 files changed

// File: rtl/tape_pkg.sv
// tape_pkg: shared defaults and FSM encoding for the tape memory arbiter
package tape_pkg;
   localparam int AW_DEF  = 25;
   localparam int TMO_DEF = 1023;
   typedef enum logic [2:0] {IDLE, GRANT_W, GRANT_R, WAIT_ACK, DONE} state_t;
endpackage

// File: rtl/tape_mem_arbiter.sv
// tape_mem_arbiter: shares the tape-image SDRAM port between download writes and cassette reads
module tape_mem_arbiter
   import tape_pkg::*;
#(
   parameter int AW         = AW_DEF,
   parameter int TMO_CYCLES = TMO_DEF
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          w_req,
   input  logic [AW-1:0] w_addr,
   input  logic [7:0]    w_data,
   output logic          w_ack,
   input  logic          dl_active,
   input  logic          r_req,
   input  logic [AW-1:0] r_addr,
   output logic [7:0]    r_data,
   output logic          r_ack,
   output logic [AW-1:0] tape_end,
   output logic          sd_req,
   output logic          sd_we,
   output logic [AW-1:0] sd_addr,
   output logic [7:0]    sd_din,
   input  logic [7:0]    sd_dout,
   input  logic          sd_ack,
   output logic          err_tmo
);
   localparam int CW = (TMO_CYCLES > 0) ? $clog2(TMO_CYCLES + 1) : 1;
   state_t        state, state_nx;
   logic [AW-1:0] addr_q;
   logic [7:0]    din_q;
   logic          we_q;
   logic [CW-1:0] cnt;
   logic          dl_q;
   logic          dl_rise;
   logic          tmo;
   logic          wait_ack;
   assign dl_rise  = dl_active & ~dl_q;
   assign wait_ack = (state == WAIT_ACK);
   // tmo fires on the last allowed waiting cycle; a simultaneous sd_ack still wins
   assign tmo      = (TMO_CYCLES != 0) && (cnt == CW'(TMO_CYCLES - 1));
   assign sd_req   = (state == GRANT_W) || (state == GRANT_R) || wait_ack;
   assign sd_we    = we_q;
   assign sd_addr  = addr_q;
   assign sd_din   = din_q;
   assign w_ack    = (state == DONE) && we_q;
   assign r_ack    = (state == DONE) && !we_q;
   // next state: W has fixed priority, R is held off during a download; timeouts finish through DONE so the ack still pulses
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:             state_nx = w_req ? GRANT_W : (r_req && !dl_active) ? GRANT_R : IDLE;
         GRANT_W, GRANT_R: state_nx = WAIT_ACK;
         WAIT_ACK:         state_nx = (sd_ack || tmo) ? DONE : WAIT_ACK;
         default:          state_nx = IDLE;
      endcase
   end
   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end
   // latch the winning request so the SDRAM side only ever sees registered values
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q <= '0;
         din_q  <= '0;
         we_q   <= 1'b0;
      end else if (state_nx == GRANT_W) begin
         addr_q <= w_addr;
         din_q  <= w_data;
         we_q   <= 1'b1;
      end else if (state_nx == GRANT_R) begin
         addr_q <= r_addr;
         we_q   <= 1'b0;
      end
   end
   // count cycles spent waiting for sd_ack
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt <= '0;
      else          cnt <= wait_ack ? cnt + 1'b1 : '0;
   end
   // capture read data (zero on timeout) and keep the sticky timeout flag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_data  <= 8'h00;
         err_tmo <= 1'b0;
      end else begin
         if (wait_ack && !we_q && (sd_ack || tmo)) r_data <= sd_ack ? sd_dout : 8'h00;
         if (dl_rise) err_tmo <= 1'b0;
         if (wait_ack && !sd_ack && tmo) err_tmo <= 1'b1;
      end
   end
   // image length tracking: cleared when a download starts, grows with the highest written address
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tape_end <= '0;
         dl_q     <= 1'b0;
      end else begin
         dl_q <= dl_active;
         if (dl_rise) tape_end <= '0;
         else if (w_ack && dl_active && (addr_q > tape_end)) tape_end <= addr_q;
      end
   end
endmodule
